// File: rtl/pc_gen.sv
// Fetch-stage program counter: registered PC, next-PC selection for
// sequential/branch/jump/return, and a circular return-address stack.
module pc_gen #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h0000_3000),
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [2:0]                   npc_sel,
    input  logic                         zero,
    input  logic [WIDTH-1:0]             gpr_rs,
    input  logic [31:0]                  imm32,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             pc4,
    output logic                         taken,
    output logic [WIDTH-1:0]             ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
    output logic                         ras_miss
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] SEL_SEQ  = 3'b000;
    localparam logic [2:0] SEL_BEQ  = 3'b001;
    localparam logic [2:0] SEL_BNE  = 3'b010;
    localparam logic [2:0] SEL_J    = 3'b011;
    localparam logic [2:0] SEL_JAL  = 3'b100;
    localparam logic [2:0] SEL_JR   = 3'b101;
    localparam logic [2:0] SEL_JRET = 3'b110;

    typedef logic [WIDTH-1:0] word_t;

    word_t          pc_q, pc_d;
    word_t          ras_q [RAS_DEPTH];
    word_t          ras_d [RAS_DEPTH];
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           miss_q, miss_d;

    word_t          btgt;
    word_t          jtgt;
    word_t          npc;
    word_t          top_entry;
    logic [PW-1:0]  top_idx;
    logic           ras_empty;
    logic           ras_full;
    logic           push;
    logic           pop;
    logic           unused_imm;

    assign unused_imm = ^imm32[31:26];

    assign pc4  = pc_q + WIDTH'(4);
    assign btgt = pc4 + {{(WIDTH-18){imm32[15]}}, imm32[15:0], 2'b00};

    generate
        if (WIDTH > 28) begin : g_jtgt_hi
            assign jtgt = {pc4[WIDTH-1:28], imm32[25:0], 2'b00};
        end else begin : g_jtgt_lo
            assign jtgt = {imm32[25:0], 2'b00};
        end
    endgenerate

    // ptr_q points at the next free slot; the top entry sits one below it.
    assign top_idx   = ptr_q - PW'(1);
    assign top_entry = ras_q[top_idx];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

    always_comb begin
        npc = pc4;
        case (npc_sel)
            SEL_SEQ:  npc = pc4;
            SEL_BEQ:  npc = zero ? btgt : pc4;
            SEL_BNE:  npc = zero ? pc4 : btgt;
            SEL_J:    npc = jtgt;
            SEL_JAL:  npc = jtgt;
            SEL_JR:   npc = gpr_rs;
            SEL_JRET: npc = gpr_rs;
            default:  npc = pc4;
        endcase
    end

    assign push = !stall && (npc_sel == SEL_JAL);
    assign pop  = !stall && (npc_sel == SEL_JRET);

    always_comb begin
        pc_d   = stall ? pc_q : npc;
        ras_d  = ras_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        miss_d = 1'b0;
        if (push) begin
            // When full, ptr_q already addresses the oldest entry, so it is overwritten.
            ras_d[ptr_q] = pc4;
            ptr_d        = ptr_q + PW'(1);
            if (!ras_full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop) begin
            if (ras_empty) begin
                miss_d = 1'b1;
            end else begin
                miss_d = (top_entry != gpr_rs);
                ptr_d  = top_idx;
                cnt_d  = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            ptr_q  <= '0;
            cnt_q  <= '0;
            miss_q <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            miss_q <= miss_d;
            ras_q  <= ras_d;
        end
    end

    assign pc       = pc_q;
    assign taken    = (npc != pc4);
    assign ras_top  = ras_empty ? '0 : top_entry;
    assign ras_cnt  = cnt_q;
    assign ras_miss = miss_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential flow, branches with wrap, jumps,
// return-address stack push/pop/overflow/underflow, stall and reset.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  npc_sel;
    logic        zero;
    logic [31:0] gpr_rs;
    logic [31:0] imm32;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        taken;
    logic [31:0] ras_top;
    logic [2:0]  ras_cnt;
    logic        ras_miss;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_push [5];

    pc_gen dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .npc_sel  (npc_sel),
        .zero     (zero),
        .gpr_rs   (gpr_rs),
        .imm32    (imm32),
        .pc       (pc),
        .pc4      (pc4),
        .taken    (taken),
        .ras_top  (ras_top),
        .ras_cnt  (ras_cnt),
        .ras_miss (ras_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; npc_sel = 3'b000; zero = 1'b0;
        gpr_rs = 32'h0; imm32 = 32'h0;
        step();
        chk("rst_pc", pc, 32'h3000);
        chk("rst_cnt", {29'd0, ras_cnt}, 32'd0);
        chk("rst_top", ras_top, 32'h0);
        chk("rst_miss", {31'd0, ras_miss}, 32'd0);
        chk("rst_pc4", pc4, 32'h3004);
        chk("rst_taken", {31'd0, taken}, 32'd0);

        // sequential flow
        rst = 1'b0;
        step(); chk("seq1", pc, 32'h3004);
        step(); chk("seq2", pc, 32'h3008);
        step(); chk("seq3", pc, 32'h300C);
        step(); chk("seq4", pc, 32'h3010);

        // branches
        npc_sel = 3'b001; zero = 1'b1; imm32 = 32'h0000_FFFC; #1;
        chk("beq_taken", {31'd0, taken}, 32'd1);
        step(); chk("beq_back", pc, 32'h3004);
        npc_sel = 3'b010; zero = 1'b1; #1;
        chk("bne_nt_taken", {31'd0, taken}, 32'd0);
        step(); chk("bne_nt", pc, 32'h3008);
        npc_sel = 3'b010; zero = 1'b0; imm32 = 32'h0000_0003;
        step(); chk("bne_fwd", pc, 32'h3018);
        npc_sel = 3'b001; zero = 1'b0; #1;
        chk("beq_nt_taken", {31'd0, taken}, 32'd0);
        step(); chk("beq_nt", pc, 32'h301C);
        npc_sel = 3'b111;
        step(); chk("rsvd_seq", pc, 32'h3020);

        // jr to high address, then wrapping branch, then j into low region
        npc_sel = 3'b101; gpr_rs = 32'hFFFF_FFF0;
        step(); chk("jr_pc", pc, 32'hFFFF_FFF0);
        chk("jr_cnt", {29'd0, ras_cnt}, 32'd0);
        npc_sel = 3'b001; zero = 1'b1; imm32 = 32'h0000_7FFF;
        step(); chk("beq_wrap", pc, 32'h0001_FFF0);
        npc_sel = 3'b011; imm32 = 32'h0000_0C10;
        step(); chk("j_pc", pc, 32'h3040);

        rst = 1'b1; npc_sel = 3'b000;
        step();
        rst = 1'b0;
        chk("rst2_pc", pc, 32'h3000);

        // jal / matching jret
        npc_sel = 3'b100; imm32 = 32'h0000_0C10;
        step();
        chk("jal_pc", pc, 32'h3040);
        chk("jal_top", ras_top, 32'h3004);
        chk("jal_cnt", {29'd0, ras_cnt}, 32'd1);
        npc_sel = 3'b110; gpr_rs = 32'h3004; #1;
        chk("jret_taken", {31'd0, taken}, 32'd1);
        step();
        chk("jret_pc", pc, 32'h3004);
        chk("jret_cnt", {29'd0, ras_cnt}, 32'd0);
        chk("jret_miss", {31'd0, ras_miss}, 32'd0);
        chk("jret_top", ras_top, 32'h0);

        // five pushes into a four-deep stack
        exp_pc = 32'h3004;
        for (int i = 0; i < 5; i++) begin
            npc_sel = 3'b100;
            imm32 = 32'h0000_1000 + 32'(i) * 32'h10;
            exp_push[i] = exp_pc + 32'd4;
            step();
            exp_pc = 32'h4000 + 32'(i) * 32'h40;
            chk("ovf_jal_pc", pc, exp_pc);
        end
        chk("ovf_cnt", {29'd0, ras_cnt}, 32'd4);
        chk("ovf_top", ras_top, 32'h40C4);
        for (int k = 4; k >= 1; k--) begin
            npc_sel = 3'b110; gpr_rs = exp_push[k];
            step();
            chk("pop_pc", pc, exp_push[k]);
            chk("pop_miss", {31'd0, ras_miss}, 32'd0);
            chk("pop_cnt", {29'd0, ras_cnt}, 32'(k - 1));
        end
        npc_sel = 3'b110; gpr_rs = 32'h3008;
        step();
        chk("under_miss", {31'd0, ras_miss}, 32'd1);
        chk("under_cnt", {29'd0, ras_cnt}, 32'd0);
        chk("under_pc", pc, 32'h3008);
        npc_sel = 3'b000;
        step();
        chk("under_miss_clr", {31'd0, ras_miss}, 32'd0);
        chk("under_next_pc", pc, 32'h300C);

        // stall across a jal
        stall = 1'b1; npc_sel = 3'b100; imm32 = 32'h0000_0C10; #1;
        chk("stall_taken", {31'd0, taken}, 32'd1);
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall_pc", pc, 32'h300C);
            chk("stall_cnt", {29'd0, ras_cnt}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk("rel_pc", pc, 32'h3040);
        chk("rel_cnt", {29'd0, ras_cnt}, 32'd1);
        chk("rel_top", ras_top, 32'h3010);
        npc_sel = 3'b000;
        step();
        chk("rel_once_cnt", {29'd0, ras_cnt}, 32'd1);
        chk("rel_once_pc", pc, 32'h3044);

        // stalled jret must not pop or flag
        stall = 1'b1; npc_sel = 3'b110; gpr_rs = 32'h5555;
        step();
        chk("stall_jret_miss", {31'd0, ras_miss}, 32'd0);
        chk("stall_jret_cnt", {29'd0, ras_cnt}, 32'd1);
        chk("stall_jret_pc", pc, 32'h3044);

        // mismatched pop consumes the entry, then an empty pop
        stall = 1'b0; npc_sel = 3'b110; gpr_rs = 32'h1234;
        step();
        chk("mis_pc", pc, 32'h1234);
        chk("mis_miss", {31'd0, ras_miss}, 32'd1);
        chk("mis_cnt", {29'd0, ras_cnt}, 32'd0);
        gpr_rs = 32'h2000;
        step();
        chk("empty_miss", {31'd0, ras_miss}, 32'd1);
        chk("empty_pc", pc, 32'h2000);
        chk("empty_cnt", {29'd0, ras_cnt}, 32'd0);

        // reset with stall high and three entries on the stack
        npc_sel = 3'b100; imm32 = 32'h0000_0C10;
        step(); step(); step();
        chk("pre_rst_cnt", {29'd0, ras_cnt}, 32'd3);
        stall = 1'b1; rst = 1'b1;
        step();
        chk("rst3_pc", pc, 32'h3000);
        chk("rst3_cnt", {29'd0, ras_cnt}, 32'd0);
        chk("rst3_miss", {31'd0, ras_miss}, 32'd0);
        chk("rst3_top", ras_top, 32'h0);
        rst = 1'b0; stall = 1'b0; npc_sel = 3'b000;
        step();
        chk("post_rst_pc", pc, 32'h3004);
        chk("post_rst_cnt", {29'd0, ras_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
